// File: rtl/line_buffer_write_arbiter_if.sv
// Write-port bundle of the line buffer arbiter: generator and host requests,
// driver scan status, and the registered line buffer write port.
interface line_buffer_write_arbiter_if #(
  parameter int unsigned address_width = 7,
  parameter int unsigned data_width    = 48
);
  logic                     gen_valid;
  logic                     gen_ready;
  logic [address_width-1:0] gen_address;
  logic [data_width-1:0]    gen_data;
  logic                     gen_last;
  logic                     host_valid;
  logic                     host_ready;
  logic [address_width-1:0] host_address;
  logic [data_width-1:0]    host_data;
  logic                     scan_bank;
  logic                     scan_active;
  logic [address_width-1:0] write_address;
  logic [data_width-1:0]    write_data;
  logic                     write_enable;
  logic                     owner;
  logic [7:0]               blocked_count;

  // Requester / environment side
  modport master (
    output gen_valid, gen_address, gen_data, gen_last,
    output host_valid, host_address, host_data,
    output scan_bank, scan_active,
    input  gen_ready, host_ready,
    input  write_address, write_data, write_enable, owner, blocked_count
  );

  // Arbiter side
  modport slave (
    input  gen_valid, gen_address, gen_data, gen_last,
    input  host_valid, host_address, host_data,
    input  scan_bank, scan_active,
    output gen_ready, host_ready,
    output write_address, write_data, write_enable, owner, blocked_count
  );
endinterface

// File: rtl/line_buffer_write_arbiter.sv
// Line buffer write port arbiter: generator bursts have priority, host beats are
// forced in after starve_limit wait cycles. Bank guard: LINE_BUFFER_WRITE_ARBITER_BANK_GUARD_EN.
module line_buffer_write_arbiter #(
  parameter int unsigned address_width = 7,
  parameter int unsigned data_width    = 48,
  parameter int unsigned starve_limit  = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  line_buffer_write_arbiter_if.slave  bus
);
  localparam int unsigned count_width = 8;
  localparam logic [count_width-1:0] starve_max  = count_width'(starve_limit);
  localparam logic [count_width-1:0] blocked_max = '1;

  typedef enum logic [1:0] {kIdle, kGenBurst, kHostForce} state_e;

  state_e                   state_q, state_d;
  logic [count_width-1:0]   starve_q, starve_d, starve_inc_c;
  logic                     host_blocked_c;
  logic                     gen_ready_c, host_ready_c;
  logic                     gen_xfer_c, host_xfer_c;
  logic                     write_enable_q;
  logic [address_width-1:0] write_address_q;
  logic [data_width-1:0]    write_data_q;
  logic                     owner_q;

`ifdef LINE_BUFFER_WRITE_ARBITER_BANK_GUARD_EN
  logic [count_width-1:0]   blocked_q;

  assign host_blocked_c = bus.scan_active &&
                          (bus.host_address[address_width-1] == bus.scan_bank);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blocked_q <= '0;
    end else if (bus.host_valid && host_blocked_c && (blocked_q != blocked_max)) begin
      blocked_q <= blocked_q + count_width'(1);
    end
  end

  assign bus.blocked_count = blocked_q;
`else
  logic unused_scan_c;

  assign unused_scan_c      = bus.scan_active ^ bus.scan_bank;
  assign host_blocked_c     = 1'b0;
  assign bus.blocked_count  = '0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= kIdle;
    else          state_q <= state_d;
  end

  // Grants: generator wins in idle; held low while reset is asserted
  always_comb begin
    gen_ready_c  = 1'b0;
    host_ready_c = 1'b0;
    if (reset_n) begin
      case (state_q)
        kIdle: begin
          host_ready_c = !bus.gen_valid && !host_blocked_c;
          gen_ready_c  = !host_ready_c;
        end
        kGenBurst:  gen_ready_c  = 1'b1;
        kHostForce: host_ready_c = !host_blocked_c;
        default: begin
          gen_ready_c  = 1'b0;
          host_ready_c = 1'b0;
        end
      endcase
    end
  end

  assign gen_xfer_c  = bus.gen_valid  && gen_ready_c;
  assign host_xfer_c = bus.host_valid && host_ready_c;

  // Host wait count for this cycle, before the force-entry clear
  always_comb begin
    starve_inc_c = starve_q;
    if (!bus.host_valid || host_xfer_c) begin
      starve_inc_c = '0;
    end else if (starve_q != starve_max) begin
      starve_inc_c = starve_q + count_width'(1);
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      kIdle: begin
        if (gen_xfer_c && !bus.gen_last) state_d = kGenBurst;
      end
      kGenBurst: begin
        if (gen_xfer_c && bus.gen_last) begin
          state_d = kIdle;
        end else if ((starve_inc_c == starve_max) && !host_blocked_c) begin
          state_d = kHostForce;
        end
      end
      kHostForce: state_d = kGenBurst;
      default:    state_d = kIdle;
    endcase
  end

  assign starve_d = (state_d == kHostForce) ? '0 : starve_inc_c;

  // Registered write port and starve counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q        <= '0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      owner_q         <= 1'b0;
    end else begin
      starve_q       <= starve_d;
      write_enable_q <= gen_xfer_c || host_xfer_c;
      if (gen_xfer_c) begin
        write_address_q <= bus.gen_address;
        write_data_q    <= bus.gen_data;
        owner_q         <= 1'b0;
      end else if (host_xfer_c) begin
        write_address_q <= bus.host_address;
        write_data_q    <= bus.host_data;
        owner_q         <= 1'b1;
      end
    end
  end

  assign bus.gen_ready     = gen_ready_c;
  assign bus.host_ready    = host_ready_c;
  assign bus.write_enable  = write_enable_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;
  assign bus.owner         = owner_q;
endmodule

// File: tb/tb_line_buffer_write_arbiter.sv
// Bench for line_buffer_write_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a rule-level reference model.
module tb_line_buffer_write_arbiter;
  localparam int unsigned address_width = 7;
  localparam int unsigned data_width    = 48;
  localparam int unsigned starve_limit  = 8;
`ifdef LINE_BUFFER_WRITE_ARBITER_BANK_GUARD_EN
  localparam bit guard_en = 1'b1;
`else
  localparam bit guard_en = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  line_buffer_write_arbiter_if #(.address_width(address_width), .data_width(data_width)) bus ();

  line_buffer_write_arbiter #(
    .address_width(address_width),
    .data_width   (data_width),
    .starve_limit (starve_limit)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: arbitration phase flags plus expected write port contents
  bit                       m_burst, m_force;
  int                       m_wait, m_blocked;
  bit                       m_we, m_owner;
  logic [address_width-1:0] m_addr;
  logic [data_width-1:0]    m_data;
  bit                       a_gen, a_host;
  int                       we_pulses;

  task automatic model_reset();
    m_burst = 0; m_force = 0; m_wait = 0; m_blocked = 0;
    m_we = 0; m_owner = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic idle_inputs();
    bus.gen_valid = 0; bus.gen_address = '0; bus.gen_data = '0; bus.gen_last = 0;
    bus.host_valid = 0; bus.host_address = '0; bus.host_data = '0;
    bus.scan_bank = 0; bus.scan_active = 0;
  endtask

  function automatic logic [data_width-1:0] rand_data();
    return data_width'({$urandom(), $urandom()});
  endfunction

  // One clock cycle with the inputs currently applied
  task automatic step();
    bit blocked, gx, hx;
    int w;
    blocked = guard_en && bus.scan_active &&
              (bus.host_address[address_width-1] == bus.scan_bank);
    gx = bus.gen_valid && !m_force;
    hx = bus.host_valid && !blocked && (m_force || (!m_burst && !bus.gen_valid));
    @(negedge clock);
    a_gen  = bus.gen_valid && bus.gen_ready;
    a_host = bus.host_valid && bus.host_ready;
    check("gen_xfer", 64'(a_gen), 64'(gx));
    check("host_xfer", 64'(a_host), 64'(hx));
    check("ready_exclusive", 64'(bus.gen_ready && bus.host_ready), 64'(0));

    w = (bus.host_valid && !hx) ? ((m_wait < int'(starve_limit)) ? m_wait + 1 : m_wait) : 0;
    if (bus.host_valid && blocked && m_blocked < 255) m_blocked++;
    if (gx) begin
      m_we = 1; m_addr = bus.gen_address; m_data = bus.gen_data; m_owner = 0;
    end else if (hx) begin
      m_we = 1; m_addr = bus.host_address; m_data = bus.host_data; m_owner = 1;
    end else begin
      m_we = 0;
    end
    if (m_force) begin
      m_force = 0;
      m_burst = 1;
    end else begin
      if (m_burst && !(gx && bus.gen_last) && w == int'(starve_limit) && !blocked) begin
        m_force = 1;
        w = 0;
      end
      if (gx) m_burst = !bus.gen_last;
    end
    m_wait = w;

    @(posedge clock);
    #1;
    if (bus.write_enable) we_pulses++;
    check("write_enable", 64'(bus.write_enable), 64'(m_we));
    check("write_address", 64'(bus.write_address), 64'(m_addr));
    check("write_data", 64'(bus.write_data), 64'(m_data));
    check("owner", 64'(bus.owner), 64'(m_owner));
    check("blocked_count", 64'(bus.blocked_count), 64'(m_blocked));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, 64'(bus.write_enable), 64'(0));
    check({tag, "_addr"}, 64'(bus.write_address), 64'(0));
    check({tag, "_data"}, 64'(bus.write_data), 64'(0));
    check({tag, "_owner"}, 64'(bus.owner), 64'(0));
    check({tag, "_blocked"}, 64'(bus.blocked_count), 64'(0));
    check({tag, "_gen_ready"}, 64'(bus.gen_ready), 64'(0));
    check({tag, "_host_ready"}, 64'(bus.host_ready), 64'(0));
  endtask

  task automatic gen_burst(input int n, input logic [address_width-1:0] base);
    for (int i = 0; i < n; i++) begin
      bus.gen_valid   = 1;
      bus.gen_address = base + address_width'(i);
      bus.gen_data    = rand_data();
      bus.gen_last    = (i == n - 1);
      step();
    end
    bus.gen_valid = 0;
    bus.gen_last  = 0;
  endtask

  initial begin
    int idx, cyc, host_at, host_first, host_cnt;
    int g_idx, g_len;
    bit g_on;
    logic [address_width-1:0] g_base;

    reset_n = 1;
    idle_inputs();
    model_reset();
    #1 reset_n = 0;
    #1 check_reset_values("reset");
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1;
    @(posedge clock);
    #1;

    // Generator-only line burst
    we_pulses = 0;
    gen_burst(64, 7'h40);
    step();
    check("burst_we_pulses", 64'(we_pulses), 64'(64));

    // Simultaneous requests in idle: generator first, then host
    bus.gen_valid = 1; bus.gen_address = 7'h10; bus.gen_data = rand_data(); bus.gen_last = 1;
    bus.host_valid = 1; bus.host_address = 7'h05; bus.host_data = rand_data();
    step();
    check("simul_host_ready", 64'(a_host), 64'(0));
    bus.gen_valid = 0; bus.gen_last = 0;
    step();
    check("simul_host_next", 64'(a_host), 64'(1));
    idle_inputs();
    step();

    // Starvation: host waits from the first beat of a burst
    we_pulses = 0; idx = 0; cyc = 0; host_at = -1;
    bus.host_valid = 1; bus.host_address = 7'h05; bus.host_data = rand_data();
    while (idx < 64 && cyc < 200) begin
      bus.gen_valid   = 1;
      bus.gen_address = 7'h40 + address_width'(idx);
      bus.gen_data    = rand_data();
      bus.gen_last    = (idx == 63);
      step();
      if (a_gen) idx++;
      if (a_host) begin host_at = cyc; bus.host_valid = 0; end
      cyc++;
    end
    idle_inputs();
    step();
    check("starve_host_cycle", 64'(host_at), 64'(starve_limit));
    check("starve_total_writes", 64'(we_pulses), 64'(65));

    // Host targeting the scanned bank, held for 10 cycles
    host_first = 999; host_cnt = 0;
    bus.scan_active = 1; bus.scan_bank = 1;
    bus.host_valid = 1; bus.host_address = 7'h45; bus.host_data = rand_data();
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_host) begin
        host_cnt++;
        if (host_first == 999) host_first = i;
      end
    end
    check("guard_blocked_count", 64'(bus.blocked_count), guard_en ? 64'(10) : 64'(0));
    check("guard_host_accepts", 64'(host_cnt), guard_en ? 64'(0) : 64'(10));
    check("guard_first_accept", 64'(host_first), guard_en ? 64'(999) : 64'(0));
    bus.scan_active = 0;
    step();
    check("guard_release_accept", 64'(a_host), 64'(1));
    idle_inputs();
    step();

    // Reset pulsed mid-burst at beat 20
    gen_burst(20, 7'h00);
    bus.gen_valid = 1; bus.gen_address = 7'h14; bus.gen_last = 0;
    reset_n = 0;
    #1 check_reset_values("midreset");
    model_reset();
    idle_inputs();
    repeat (2) @(negedge clock);
    reset_n = 1;
    @(posedge clock);
    #1;
    we_pulses = 0;
    gen_burst(64, 7'h40);
    check("fresh_burst_we_pulses", 64'(we_pulses), 64'(64));

    // Random traffic
    g_on = 0; g_idx = 0; g_len = 1; g_base = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!g_on && $urandom_range(0, 3) == 0) begin
        g_on = 1; g_idx = 0; g_len = int'($urandom_range(1, 64));
        g_base = address_width'($urandom());
      end
      bus.gen_valid   = g_on && ($urandom_range(0, 9) < 8);
      bus.gen_address = g_base + address_width'(g_idx);
      bus.gen_data    = rand_data();
      bus.gen_last    = (g_idx == g_len - 1);
      if (!bus.host_valid) begin
        if ($urandom_range(0, 9) < 3) begin
          bus.host_valid   = 1;
          bus.host_address = address_width'($urandom());
          bus.host_data    = rand_data();
        end
      end else if ($urandom_range(0, 19) == 0) begin
        bus.host_valid = 0;
      end
      if ($urandom_range(0, 19) == 0) bus.scan_active = 1'($urandom());
      if ($urandom_range(0, 19) == 0) bus.scan_bank = 1'($urandom());
      step();
      if (a_gen) begin
        g_idx++;
        if (g_idx == g_len) g_on = 0;
      end
      if (a_host) bus.host_valid = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/line_buffer_write_arbiter.md
# line_buffer_write_arbiter

Shares the line buffer write port between the row pixel generator (burst writer, one full 64-pixel line per burst) and a host overlay writer (single-beat writes). Sits between both requesters and the line buffer write port, beside the row controller. Generator bursts get priority, with bounded host starvation. An optional bank guard blocks host writes into the bank the driver is currently scanning out.

## Interface
Parameters:
- address_width, 7, line buffer address width; MSB selects the bank, low bits select the pixel
- data_width, 48, pixel word width (two RGB pixels, 8 bit per channel)
- starve_limit, 8, host wait cycles during a generator burst before one host beat is forced in (1..255)

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- gen_valid  in  1  generator write request
- gen_ready  out  1  generator beat accepted this cycle
- gen_address  in  address_width  generator write address
- gen_data  in  data_width  generator write data
- gen_last  in  1  final beat of the generator line burst
- host_valid  in  1  host write request
- host_ready  out  1  host beat accepted this cycle
- host_address  in  address_width  host write address
- host_data  in  data_width  host write data
- scan_bank  in  1  bank the driver is currently reading
- scan_active  in  1  driver is shifting a row (driver not idle)
- write_address  out  address_width  to line buffer
- write_data  out  data_width  to line buffer
- write_enable  out  1  to line buffer
- owner  out  1  0 = generator, 1 = host; source of the last registered write
- blocked_count  out  8  saturating count of cycles a host request was bank-blocked

## Operation
- A transfer occurs when valid && ready in the same cycle. gen_ready and host_ready are combinational from the state, the starve counter and the host bank check. They are never both 1 in the same cycle.
- States: kIdle, kGenBurst, kHostForce.
- kIdle:
  - gen_valid -> accept the generator beat and go to kGenBurst. If that beat has gen_last, stay in kIdle.
  - Otherwise, if host_valid and the host is not blocked -> accept the host beat and stay in kIdle.
  - If both request in the same cycle, the generator wins.
- kGenBurst:
  - Only the generator is accepted (gen_ready = 1).
  - An accepted gen_last beat returns the state to kIdle.
  - Starve counter increments each cycle that host_valid is high and the host is unserved.
  - When the counter reaches starve_limit and the host is not blocked, go to kHostForce on the next edge.
- kHostForce:
  - host_ready = 1 and gen_ready = 0 for exactly one cycle.
  - Leave after one cycle, whether or not a host transfer happened, and return to kGenBurst.
  - The starve counter clears on entry.
- The starve counter clears whenever host_valid is low or a host beat is accepted. It saturates at starve_limit.
- Host blocked = scan_active && (host_address[address_width-1] == scan_bank). A blocked host is never granted, including in kHostForce: kHostForce is not entered while the host is blocked.
- blocked_count increments each cycle that host_valid && blocked. It saturates at 255 and is never cleared except by reset.
- Host request dropped mid-wait: the starve counter clears and no host beat is forced.

## Timing
- Latency is 1 cycle: a transfer in cycle N produces write_enable = 1 with the matching write_address/write_data/owner in cycle N+1, all registered.
- write_enable = 0 in any cycle after a cycle with no transfer. write_address/write_data hold their last values.
- Reset values: state kIdle, write_enable 0, write_address 0, write_data 0, owner 0, blocked_count 0, starve counter 0. gen_ready = 0 and host_ready = 0 while reset_n is low.
- Reset asserted mid-burst aborts the burst immediately. No write_enable is issued for a beat transferred in the cycle reset asserts.
- Sustained throughput is 1 beat per cycle. A 64-beat generator burst with no host traffic takes 64 cycles.

## Configuration
- LINE_BUFFER_WRITE_ARBITER_BANK_GUARD_EN defined: bank guard active as described above.
- Not defined:
  - host blocked is constant 0, so the host may write either bank;
  - scan_bank and scan_active are ignored;
  - blocked_count is tied to 0.

## Test plan
- Generator-only burst: 64 beats at addresses 0x40..0x7F, gen_last on 0x7F -> 64 consecutive write_enable pulses, each one cycle after its transfer, owner = 0, state back to kIdle.
- Simultaneous requests in kIdle: gen_valid and host_valid (address 0x05) -> generator granted first, host_ready = 0 that cycle.
- Starvation with starve_limit = 8: host waits from the start of a 64-beat burst -> host beat accepted in the cycle after 8 wait cycles, owner = 1 on the following cycle, burst resumes, total 65 write cycles.
- Bank guard (macro defined): scan_active = 1, scan_bank = 1, host_address 0x45 held 10 cycles -> host_ready stays 0 and blocked_count = 10. Deassert scan_active -> host is accepted.
- Same stimulus with the macro undefined -> host accepted in the first idle cycle, blocked_count = 0.
- reset_n pulsed low at beat 20 of a burst -> all outputs return to their reset values. A fresh burst after release starts from kIdle.
